frame_burst_writer: RTL and testbench
=====================================

Name: frame_burst_writer

Overview:
- Next-generation camera frame uploader.
- Drains a tagged 17-bit pixel FIFO (frame/row markers plus 16-bit RGB565 pixels) into a burst-oriented PSRAM write port.
- Adds over the previous uploader: parametrised burst length, address width and line stride, per-byte write mask for partial bursts, row-length checking, and marker-error resynchronisation.
- Sits between the camera capture FIFO and the memory arbiter's write channel.

Parameters:
- BURST_PIXELS, 32, pixels per full memory burst; even, 4..64.
- FRAME_WIDTH, 640, pixels per row.
- FRAME_HEIGHT, 480, rows per frame.
- LINE_STRIDE, 640, address increment per row, in pixel units; must be >= FRAME_WIDTH.
- ADDR_W, 21, memory address width.
- TCMD, 19, cycles from the mem_wr_en cycle to write_rq release; must be > BURST_PIXELS/2.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  pulse: arm upload of one frame
- base_addr  in  ADDR_W  frame base address, sampled when start is accepted
- queue_empty  in  1  FIFO empty (first-word fall-through)
- queue_data  in  17  FIFO head: bit16=1 is a marker (10000h SOF, 10001h SOL, 1FFFFh EOF); bit16=0 is a pixel
- rd_en  out  1  pop FIFO head
- write_rq  out  1  memory channel request
- write_ack  in  1  arbiter grant
- write_addr  out  ADDR_W  burst start address, pixel units
- mem_wr_en  out  1  one-cycle write command strobe
- write_data  out  32  beat data: {pixel n+1, pixel n}
- write_mask  out  4  per-byte mask for the current beat; 1 = byte not written
- upload_done  out  1  one-cycle pulse: frame completed cleanly
- frame_error  out  1  one-cycle pulse: frame aborted
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset values: all outputs 0; write_mask = 4'hF; state IDLE; all counters 0.
- FIFO rule: a word is consumed in a cycle iff rd_en & !queue_empty. queue_data is valid only when !queue_empty.
- States and transitions:
  - IDLE: on start, latch base_addr into row_base and go to WAIT_SOF. start is ignored outside IDLE.
  - WAIT_SOF: pop and discard words until SOF is consumed. Then row=0 and go to WAIT_SOL.
  - WAIT_SOL: pixels or SOF -> error. EOF with row<FRAME_HEIGHT -> error. SOL consumed -> col=0, go to FILL.
  - FILL: target n = min(BURST_PIXELS, FRAME_WIDTH-col). Pop pixels into the cache at index 0..n-1. After the n-th pixel, rd_en drops in the same cycle; go to REQ. Any marker while filling -> error. FIFO empty -> stall, rd_en stays high.
  - REQ: write_rq=1, write_addr = row_base + col. Wait for write_ack.
  - BURST: mem_wr_en=1 in the first cycle only, beat 0 on write_data in that cycle. Beats 1..BURST_PIXELS/2-1 follow on consecutive cycles.
  - Beat mask: the beat holding pixels 2k and 2k+1 has mask bits [1:0] set iff 2k>=n, and bits [3:2] set iff 2k+1>=n. Beats past n are fully masked.
  - TAIL: write_rq held until TCMD cycles after the mem_wr_en cycle, then dropped. col += n.
  - Next step after TAIL: col<FRAME_WIDTH -> FILL. Otherwise row++ and row_base += LINE_STRIDE; then row<FRAME_HEIGHT -> WAIT_SOL, else WAIT_EOF.
  - WAIT_EOF: EOF -> upload_done pulse, go to IDLE. SOL, SOF or a pixel -> error.
  - Error: frame_error pulse, go to WAIT_SOF (resync). The partially written frame is not rewritten. Error is never taken while write_rq=1, because markers are only examined in FILL, WAIT_SOL and WAIT_EOF.
- Latency:
  - write_ack high in cycle t -> mem_wr_en in cycle t+1.
  - mem_wr_en in cycle s -> write_rq low in cycle s+TCMD.
  - write_rq low -> rd_en high no earlier than the next cycle.
- Width and arithmetic rules:
  - col: clog2(FRAME_WIDTH+1) bits. row: clog2(FRAME_HEIGHT+1) bits.
  - row_base addition wraps modulo 2^ADDR_W and is not flagged.
- Reset mid-burst: all outputs drop asynchronously. The arbiter handles the abandoned grant.

Decomposition:
- Shared package frame_burst_writer_pkg:
  - state enum
  - marker constants MARK_SOF, MARK_SOL, MARK_EOF
  - function min_load(col) returning n
- Sub-module burst_pixel_cache:
  - 16-bit write port, 32-bit read port, depth BURST_PIXELS.
  - Read data registered, 1-cycle latency; the FSM pre-reads beat 0 in REQ so data is valid in the mem_wr_en cycle.

Test Plan:
- Clean frame (WIDTH=40, HEIGHT=2, STRIDE=64, BURST=16, base=100h):
  - Bursts at 100h, 110h, 120h, 140h, 150h, 160h; third burst of each row n=8.
  - upload_done exactly once after EOF.
- Odd partial burst (WIDTH=21, BURST=16):
  - Second burst beat 2 mask = 4'hC; beats 3..7 mask = 4'hF.
  - Beats 0..1 mask = 0; pixel values match the input ramp.
- Unexpected SOL after 5 pixels of a row:
  - frame_error pulse, no burst for that chunk.
  - Subsequent SOF -> frame restarts at base, completes cleanly.
- Arbiter stall: write_ack held low 50 cycles -> write_rq stays high, rd_en stays low, no FIFO pops.
- FIFO starvation: queue_empty toggled every other cycle during FILL -> same addresses and data as the clean case.
- Timing and reset:
  - write_ack at cycle t -> mem_wr_en at t+1, write_rq low at t+1+TCMD.
  - reset_n pulsed low mid-BURST -> all outputs reset; next start is accepted normally.

Source files
------------

// File: rtl/frame_burst_writer_pkg.sv
// Shared types and helpers for the camera frame burst writer.
// Holds the FSM state encoding, the FIFO marker words and the burst-size helper.
package frame_burst_writer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_SOF,
    ST_WAIT_SOL,
    ST_FILL,
    ST_REQ,
    ST_BURST,
    ST_TAIL,
    ST_STEP,
    ST_WAIT_EOF
  } fbw_state_e;

  localparam logic [16:0] MARK_SOF = 17'h10000;
  localparam logic [16:0] MARK_SOL = 17'h10001;
  localparam logic [16:0] MARK_EOF = 17'h1FFFF;

  // Pixels in the next burst: a full burst, or whatever is left of the row.
  function automatic int min_load(input int col, input int width, input int burst);
    return ((width - col) < burst) ? (width - col) : burst;
  endfunction

endpackage

// File: rtl/burst_pixel_cache.sv
// One-burst pixel buffer: 16-bit pixel writes, 32-bit beat reads {odd, even}.
// Read data is registered, so a beat address presented in cycle t appears in t+1.
module burst_pixel_cache #(
  parameter int BURST_PIXELS = 32
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                wr_en,
  input  logic [$clog2(BURST_PIXELS)-1:0]     wr_addr,
  input  logic [15:0]                         wr_data,
  input  logic [$clog2(BURST_PIXELS/2)-1:0]   rd_addr,
  output logic [31:0]                         rd_data
);

  localparam int BEATS = BURST_PIXELS / 2;
  localparam int PW    = $clog2(BURST_PIXELS);

  // Even and odd pixels live in separate banks so one read returns a full beat.
  logic [15:0] even_mem [BEATS];
  logic [15:0] odd_mem  [BEATS];
  logic [31:0] rd_data_d;
  logic [31:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_addr[0]) odd_mem[wr_addr[PW-1:1]]  <= wr_data;
      else            even_mem[wr_addr[PW-1:1]] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = {odd_mem[rd_addr], even_mem[rd_addr]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_data_q <= '0;
    else          rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/frame_burst_writer.sv
// Drains a tagged pixel FIFO (SOF/SOL/EOF markers plus RGB565 pixels) into
// masked PSRAM write bursts, checking row structure and resyncing on errors.
module frame_burst_writer
  import frame_burst_writer_pkg::*;
#(
  parameter int BURST_PIXELS = 32,
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int LINE_STRIDE  = 640,
  parameter int ADDR_W       = 21,
  parameter int TCMD         = 19
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              queue_empty,
  input  logic [16:0]       queue_data,
  output logic              rd_en,
  output logic              write_rq,
  input  logic              write_ack,
  output logic [ADDR_W-1:0] write_addr,
  output logic              mem_wr_en,
  output logic [31:0]       write_data,
  output logic [3:0]        write_mask,
  output logic              upload_done,
  output logic              frame_error,
  output logic              busy
);

  localparam int CW    = $clog2(FRAME_WIDTH + 1);
  localparam int RW    = $clog2(FRAME_HEIGHT + 1);
  localparam int FW    = $clog2(BURST_PIXELS + 1);
  localparam int PW    = $clog2(BURST_PIXELS);
  localparam int BW    = $clog2(BURST_PIXELS / 2);
  localparam int TW    = $clog2(TCMD + 1);
  localparam int BEATS = BURST_PIXELS / 2;

  fbw_state_e        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic [TW-1:0]     cyc_q, cyc_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              pop;
  logic [FW-1:0]     load_n;
  logic [FW-1:0]     fill_inc;
  int                col_next;
  logic              cache_we;
  logic [BW-1:0]     cache_rd_addr;
  logic              mask_lo, mask_hi;

  assign pop      = rd_en & ~queue_empty;
  assign load_n   = FW'(min_load(int'(col_q), FRAME_WIDTH, BURST_PIXELS));
  assign fill_inc = fill_q + FW'(1);
  assign col_next = int'(col_q) + int'(load_n);
  assign mask_lo  = (2 * int'(cyc_q)) >= int'(load_n);
  assign mask_hi  = (2 * int'(cyc_q) + 1) >= int'(load_n);

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    row_base_d    = row_base_q;
    row_d         = row_q;
    col_d         = col_q;
    fill_d        = fill_q;
    cyc_d         = cyc_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    rd_en         = 1'b0;
    write_rq      = 1'b0;
    mem_wr_en     = 1'b0;
    write_mask    = 4'hF;
    cache_we      = 1'b0;
    cache_rd_addr = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          state_d = ST_WAIT_SOF;
        end
      end
      ST_WAIT_SOF: begin
        rd_en = 1'b1;
        if (pop && queue_data == MARK_SOF) begin
          row_d      = '0;
          row_base_d = base_q;
          state_d    = ST_WAIT_SOL;
        end
      end
      ST_WAIT_SOL: begin
        rd_en = 1'b1;
        if (pop) begin
          if (queue_data == MARK_SOL) begin
            col_d   = '0;
            fill_d  = '0;
            state_d = ST_FILL;
          end else begin
            err_d   = 1'b1;
            state_d = ST_WAIT_SOF;
          end
        end
      end
      ST_FILL: begin
        rd_en = 1'b1;
        if (pop) begin
          if (queue_data[16]) begin
            err_d   = 1'b1;
            state_d = ST_WAIT_SOF;
          end else begin
            cache_we = 1'b1;
            fill_d   = fill_inc;
            if (fill_inc == load_n) state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        // Pre-read beat 0 so it is on write_data in the mem_wr_en cycle.
        write_rq = 1'b1;
        cyc_d    = '0;
        if (write_ack) state_d = ST_BURST;
      end
      ST_BURST: begin
        write_rq   = 1'b1;
        mem_wr_en  = (cyc_q == '0);
        write_mask = {mask_hi, mask_hi, mask_lo, mask_lo};
        cyc_d      = cyc_q + TW'(1);
        if (cyc_q < TW'(BEATS - 1)) cache_rd_addr = BW'(int'(cyc_q) + 1);
        if (cyc_q == TW'(BEATS - 1)) state_d = ST_TAIL;
      end
      ST_TAIL: begin
        write_rq = 1'b1;
        cyc_d    = cyc_q + TW'(1);
        if (cyc_q == TW'(TCMD - 1)) state_d = ST_STEP;
      end
      ST_STEP: begin
        // One idle cycle after write_rq drops keeps the FIFO quiet while the arbiter releases.
        col_d = CW'(col_next);
        if (col_next < FRAME_WIDTH) begin
          fill_d  = '0;
          state_d = ST_FILL;
        end else begin
          row_d      = row_q + RW'(1);
          row_base_d = row_base_q + ADDR_W'(LINE_STRIDE);
          if (int'(row_q) + 1 < FRAME_HEIGHT) state_d = ST_WAIT_SOL;
          else                                state_d = ST_WAIT_EOF;
        end
      end
      ST_WAIT_EOF: begin
        rd_en = 1'b1;
        if (pop) begin
          if (queue_data == MARK_EOF) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_WAIT_SOF;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      row_base_q <= '0;
      row_q      <= '0;
      col_q      <= '0;
      fill_q     <= '0;
      cyc_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      row_base_q <= row_base_d;
      row_q      <= row_d;
      col_q      <= col_d;
      fill_q     <= fill_d;
      cyc_q      <= cyc_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  burst_pixel_cache #(
    .BURST_PIXELS(BURST_PIXELS)
  ) u_cache (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (cache_we),
    .wr_addr (fill_q[PW-1:0]),
    .wr_data (queue_data[15:0]),
    .rd_addr (cache_rd_addr),
    .rd_data (write_data)
  );

  assign write_addr  = write_rq ? (row_base_q + ADDR_W'(col_q)) : '0;
  assign upload_done = done_q;
  assign frame_error = err_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_frame_burst_writer.sv
// Self-checking bench for frame_burst_writer: FIFO and arbiter models,
// a beat scoreboard fed from the pixel stream, and latency/reset checks.
module tb_frame_burst_writer;
  import frame_burst_writer_pkg::*;

  localparam int BP     = 16;
  localparam int FWID   = 37;
  localparam int FHGT   = 2;
  localparam int STRIDE = 64;
  localparam int AW     = 21;
  localparam int TCMD   = 12;
  localparam int W      = AW + 36;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          queue_empty;
  logic [16:0]   queue_data;
  logic          rd_en;
  logic          write_rq;
  logic          write_ack = 1'b0;
  logic [AW-1:0] write_addr;
  logic          mem_wr_en;
  logic [31:0]   write_data;
  logic [3:0]    write_mask;
  logic          upload_done;
  logic          frame_error;
  logic          busy;

  frame_burst_writer #(
    .BURST_PIXELS(BP), .FRAME_WIDTH(FWID), .FRAME_HEIGHT(FHGT),
    .LINE_STRIDE(STRIDE), .ADDR_W(AW), .TCMD(TCMD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .queue_empty(queue_empty), .queue_data(queue_data), .rd_en(rd_en),
    .write_rq(write_rq), .write_ack(write_ack), .write_addr(write_addr),
    .mem_wr_en(mem_wr_en), .write_data(write_data), .write_mask(write_mask),
    .upload_done(upload_done), .frame_error(frame_error), .busy(busy)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- FIFO model ----------------
  logic [16:0] fmem [0:4095];
  int   wp = 0;
  int   rp = 0;
  logic starve = 1'b0;
  bit   starve_en = 1'b0;
  assign queue_empty = (rp == wp) || starve;
  assign queue_data  = fmem[rp[11:0]];

  initial forever begin
    bit pop;
    @(negedge clk);
    pop = rd_en && !queue_empty;
    @(posedge clk);
    #1;
    if (pop && reset_n) rp++;
    starve = starve_en ? ~starve : 1'b0;
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int wr_cnt   = 0;
  int rd_viol  = 0;
  bit stall_next = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack_beat(input logic [AW-1:0] a, input logic [31:0] d,
                                             input logic [3:0] m);
    logic [31:0] keep;
    for (int i = 0; i < 4; i++) keep[i*8 +: 8] = m[i] ? 8'h00 : 8'hFF;
    return {a, d & keep, m};
  endfunction

  // ---------------- arbiter model ----------------
  initial forever begin
    @(negedge clk);
    if (reset_n && write_rq) begin
      int d;
      int rp0;
      int guard;
      bit dropped;
      d       = stall_next ? 50 : $urandom_range(0, 3);
      rp0     = rp;
      dropped = 1'b0;
      repeat (d) begin
        @(negedge clk);
        if (!write_rq || rd_en) dropped = 1'b1;
      end
      if (stall_next) begin
        check_val("stall_rq_held_rd_low", dropped, 0);
        check_val("stall_no_pop", rp, rp0);
        stall_next = 1'b0;
      end
      @(posedge clk); #1 write_ack = 1'b1;
      @(posedge clk); #1 write_ack = 1'b0;
      guard = 0;
      while (write_rq && guard < 100) begin
        @(negedge clk);
        guard++;
      end
    end
  end

  // ---------------- output monitor ----------------
  initial begin
    int ack_cyc;
    int wr_cyc;
    int beat_i;
    bit beat_act;
    bit prev_rq;
    logic [W-1:0] exp_e;
    ack_cyc = -10; wr_cyc = -100; beat_i = 0; beat_act = 0; prev_rq = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        beat_act = 1'b0;
        prev_rq  = 1'b0;
      end else begin
        if (write_ack) ack_cyc = cyc;
        if (mem_wr_en) begin
          check_val("ack_to_wr_en", cyc, ack_cyc + 1);
          beat_act = 1'b1;
          beat_i   = 0;
          wr_cyc   = cyc;
          wr_cnt++;
        end
        if (beat_act) begin
          exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
          check_val("burst_beat", pack_beat(write_addr, write_data, write_mask), exp_e);
          beat_i++;
          if (beat_i == BP / 2) beat_act = 1'b0;
        end
        if (prev_rq && !write_rq) check_val("rq_release", cyc, wr_cyc + TCMD);
        if (rd_en && (write_rq || prev_rq)) rd_viol++;
        if (upload_done) done_cnt++;
        if (frame_error) err_cnt++;
        prev_rq = write_rq;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_word(input logic [16:0] w);
    fmem[wp[11:0]] = w;
    wp++;
  endtask

  task automatic push_frame(input logic [AW-1:0] base);
    logic [15:0] line [FWID];
    push_word(MARK_SOF);
    for (int r = 0; r < FHGT; r++) begin
      push_word(MARK_SOL);
      for (int c = 0; c < FWID; c++) begin
        line[c] = 16'($urandom);
        push_word({1'b0, line[c]});
      end
      for (int c0 = 0; c0 < FWID; c0 += BP) begin
        int n;
        logic [AW-1:0] a;
        n = (FWID - c0 < BP) ? (FWID - c0) : BP;
        a = base + AW'(r * STRIDE + c0);
        for (int k = 0; k < BP / 2; k++) begin
          logic lo_m, hi_m;
          logic [15:0] pl, ph;
          lo_m = (2 * k >= n);
          hi_m = (2 * k + 1 >= n);
          pl = 16'h0;
          ph = 16'h0;
          if (!lo_m) pl = line[c0 + 2 * k];
          if (!hi_m) ph = line[c0 + 2 * k + 1];
          exp_q.push_back(pack_beat(a, {ph, pl}, {hi_m, hi_m, lo_m, lo_m}));
        end
      end
    end
    push_word(MARK_EOF);
  endtask

  task automatic do_start(input logic [AW-1:0] base);
    @(posedge clk); #1;
    base_addr = base;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_done(input int target, input string tag);
    int g;
    g = 0;
    while (done_cnt < target && g < 5000) begin
      @(negedge clk);
      g++;
    end
    repeat (3) @(negedge clk);
    check_val(tag, done_cnt, target);
    check_val("scoreboard_drained", exp_q.size(), 0);
    check_val("idle_after_frame", busy, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int g;
    int wr0;
    for (int i = 0; i < 4096; i++) fmem[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_rd_en", rd_en, 0);
    check_val("rst_write_rq", write_rq, 0);
    check_val("rst_mem_wr_en", mem_wr_en, 0);
    check_val("rst_write_mask", write_mask, 4'hF);
    check_val("rst_write_data", write_data, 0);
    check_val("rst_write_addr", write_addr, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_upload_done", upload_done, 0);
    check_val("rst_frame_error", frame_error, 0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    check_val("post_rst_busy", busy, 0);
    check_val("post_rst_rd_en", rd_en, 0);

    // Clean frame with junk ahead of SOF.
    do_start(21'h100);
    check_val("busy_after_start", busy, 1);
    push_word({1'b0, 16'hBEEF});
    push_word(MARK_EOF);
    push_word(MARK_SOL);
    push_frame(21'h100);
    wait_done(1, "clean_done");
    check_val("clean_no_error", err_cnt, 0);

    // Unexpected SOL mid-row, then a clean resync frame.
    do_start(21'h200);
    push_word(MARK_SOF);
    push_word(MARK_SOL);
    for (int i = 0; i < 5; i++) push_word({1'b0, 16'($urandom)});
    push_word(MARK_SOL);
    push_frame(21'h200);
    wait_done(2, "resync_done");
    check_val("resync_error_pulses", err_cnt, 1);

    // Arbiter holds off the first grant for 50 cycles.
    stall_next = 1'b1;
    do_start(21'h300);
    push_frame(21'h300);
    wait_done(3, "stall_done");

    // FIFO starved every other cycle.
    starve_en = 1'b1;
    do_start(21'h100);
    push_frame(21'h100);
    wait_done(4, "starve_done");
    starve_en = 1'b0;

    // Reset in the middle of a burst.
    do_start(21'h400);
    push_frame(21'h400);
    wr0 = wr_cnt;
    g = 0;
    while (wr_cnt == wr0 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check_val("rst_burst_seen", wr_cnt - wr0, 1);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check_val("midrst_write_rq", write_rq, 0);
    check_val("midrst_mem_wr_en", mem_wr_en, 0);
    check_val("midrst_rd_en", rd_en, 0);
    check_val("midrst_busy", busy, 0);
    check_val("midrst_write_mask", write_mask, 4'hF);
    check_val("midrst_write_data", write_data, 0);
    exp_q.delete();
    wp = rp;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    do_start(21'h500);
    push_frame(21'h500);
    wait_done(5, "after_reset_done");

    check_val("total_error_pulses", err_cnt, 1);
    check_val("rd_en_while_rq", rd_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

endmodule
